// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB register-table initialisation sequencer:
// table entry opcodes and field positions, SCCB transaction ops, FSM states.
package sccb_pkg;

    // Table entry opcodes, entry[23:22]
    localparam logic [1:0] ENT_WRITE  = 2'b00;
    localparam logic [1:0] ENT_VERIFY = 2'b01;
    localparam logic [1:0] ENT_DELAY  = 2'b10;
    localparam logic [1:0] ENT_END    = 2'b11;

    // SCCB master transaction ops, sccb_data[25:24]
    localparam logic [1:0] SCCB_OP_WR  = 2'b00;
    localparam logic [1:0] SCCB_OP_RD1 = 2'b01;
    localparam logic [1:0] SCCB_OP_RD2 = 2'b10;

    // Table entry field positions
    localparam int ENT_OP_HI  = 23;
    localparam int ENT_OP_LO  = 22;
    localparam int ENT_SUB_HI = 15;
    localparam int ENT_SUB_LO = 8;
    localparam int ENT_DAT_HI = 7;
    localparam int ENT_DAT_LO = 0;
    localparam int ENT_DLY_HI = 15;
    localparam int ENT_DLY_LO = 0;

    // DELAY length is in units of 1024 clk cycles
    localparam int DLY_SHIFT = 10;

    // Shared timer width: covers 16-bit DELAY x 1024 and the 24-bit timeout
    localparam int TMR_W = 26;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_ACK,
        S_XFER,
        S_GAP,
        S_DELAY,
        S_CHECK,
        S_DONE
    } state_e;

endpackage

// File: rtl/sccb_tick_timer.sv
// Loadable down-counter with zero flag. Holds at zero; a load overrides
// the decrement. Shared by the GAP, DELAY and transaction-timeout phases.
module sccb_tick_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q, count_d;

    // Next count: load wins, otherwise count down and stop at zero
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sccb_init_seq.sv
// Walks an external register table and turns each entry into SCCB
// transactions (write, verify read-back, delay, end), with inter-transaction
// gaps, a per-transaction timeout and sticky error reporting.
module sccb_init_seq
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ID       = 8'h42,
    parameter int          ADDR_W       = 8,
    parameter logic [15:0] GAP_CYC      = 16'd200,
    parameter logic [23:0] XFER_TIMEOUT = 24'd1_000_000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              sccb_start,
    output logic [25:0]       sccb_data,
    input  logic              sccb_busy,
    input  logic [7:0]        sccb_rdata,
    output logic              running,
    output logic              done,
    output logic              err_verify,
    output logic              err_timeout,
    output logic [ADDR_W-1:0] err_index
);

    localparam logic [ADDR_W-1:0] IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;
    localparam logic [7:0]        DEV_WADDR = {DEV_ID[7:1], 1'b0};
    localparam logic [TMR_W-1:0]  TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
    // Timer loads are one less than the cycle count: the zero cycle itself counts
    localparam logic [TMR_W-1:0]  TMO_LOAD  = (XFER_TIMEOUT == 24'd0) ? '0 :
        {{(TMR_W-24){1'b0}}, XFER_TIMEOUT} - TMR_ONE;
    localparam logic [TMR_W-1:0]  GAP_LOAD  = (GAP_CYC == 16'd0) ? '0 :
        {{(TMR_W-16){1'b0}}, GAP_CYC} - TMR_ONE;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] err_index_q, err_index_d;
    logic [25:0]       sccb_data_q, sccb_data_d;
    logic [7:0]        exp_q, exp_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              err_verify_q, err_verify_d;
    logic              err_timeout_q, err_timeout_d;
    logic [1:0]        ack_cnt_q, ack_cnt_d;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;
    logic              advance, fail_tmo, err_any;
    logic [5:0]        entry_rsvd_unused;

    // Entry bits [21:16] are reserved and deliberately ignored
    assign entry_rsvd_unused = rom_data[21:16];
    assign err_any = err_verify_q | err_timeout_q;

    sccb_tick_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state, table walk, transaction and error bookkeeping
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        err_index_d   = err_index_q;
        sccb_data_d   = sccb_data_q;
        exp_d         = exp_q;
        rdata_d       = rdata_q;
        err_verify_d  = err_verify_q;
        err_timeout_d = err_timeout_q;
        ack_cnt_d     = ack_cnt_q;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        advance       = 1'b0;
        fail_tmo      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    index_d       = '0;
                    err_index_d   = '0;
                    err_verify_d  = 1'b0;
                    err_timeout_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            // rom_addr already shows index; the ROM answers next cycle
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (rom_data[ENT_OP_HI:ENT_OP_LO])
                    ENT_WRITE: begin
                        sccb_data_d = {SCCB_OP_WR, DEV_WADDR,
                                       rom_data[ENT_SUB_HI:ENT_SUB_LO],
                                       rom_data[ENT_DAT_HI:ENT_DAT_LO]};
                        state_d     = S_ISSUE;
                    end
                    ENT_VERIFY: begin
                        sccb_data_d = {SCCB_OP_RD1, DEV_WADDR,
                                       rom_data[ENT_SUB_HI:ENT_SUB_LO], 8'h00};
                        exp_d       = rom_data[ENT_DAT_HI:ENT_DAT_LO];
                        state_d     = S_ISSUE;
                    end
                    ENT_DELAY: begin
                        tmr_load = 1'b1;
                        tmr_val  = {rom_data[ENT_DLY_HI:ENT_DLY_LO], {DLY_SHIFT{1'b0}}};
                        state_d  = S_DELAY;
                    end
                    ENT_END: state_d = S_DONE;
                endcase
            end
            // Timeout budget starts counting from the request cycle
            S_ISSUE: begin
                tmr_load  = 1'b1;
                tmr_val   = TMO_LOAD;
                ack_cnt_d = 2'd0;
                state_d   = S_ACK;
            end
            S_ACK: begin
                if (sccb_busy) begin
                    state_d = S_XFER;
                end else if (tmr_zero || ack_cnt_q == 2'd3) begin
                    fail_tmo = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + 2'd1;
                end
            end
            S_XFER: begin
                if (!sccb_busy) begin
                    rdata_d  = sccb_rdata;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = S_GAP;
                end else if (tmr_zero) begin
                    fail_tmo = 1'b1;
                end
            end
            // After the gap: second read phase, compare, or next entry
            S_GAP: begin
                if (tmr_zero) begin
                    case (sccb_data_q[25:24])
                        SCCB_OP_RD1: begin
                            sccb_data_d[25:24] = SCCB_OP_RD2;
                            state_d            = S_ISSUE;
                        end
                        SCCB_OP_RD2: state_d = S_CHECK;
                        default:     advance = 1'b1;
                    endcase
                end
            end
            S_DELAY: begin
                if (tmr_zero) begin
                    advance = 1'b1;
                end
            end
            S_CHECK: begin
                if (rdata_q != exp_q) begin
                    err_verify_d = 1'b1;
                    if (!err_any) begin
                        err_index_d = index_q;
                    end
                end
                advance = 1'b1;
            end
            S_DONE: begin
                index_d     = '0;
                sccb_data_d = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            index_d = index_q + IDX_ONE;
            state_d = (index_q == IDX_LAST) ? S_DONE : S_FETCH;
        end

        if (fail_tmo) begin
            err_timeout_d = 1'b1;
            if (!err_any) begin
                err_index_d = index_q;
            end
            state_d = S_DONE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            index_q       <= '0;
            err_index_q   <= '0;
            sccb_data_q   <= '0;
            exp_q         <= '0;
            rdata_q       <= '0;
            err_verify_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            ack_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            err_index_q   <= err_index_d;
            sccb_data_q   <= sccb_data_d;
            exp_q         <= exp_d;
            rdata_q       <= rdata_d;
            err_verify_q  <= err_verify_d;
            err_timeout_q <= err_timeout_d;
            ack_cnt_q     <= ack_cnt_d;
        end
    end

    assign rom_addr    = index_q;
    assign sccb_start  = (state_q == S_ISSUE);
    assign sccb_data   = sccb_data_q;
    assign running     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign err_verify  = err_verify_q;
    assign err_timeout = err_timeout_q;
    assign err_index   = err_index_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Self-checking bench for sccb_init_seq: directed scenarios plus random
// tables compared against a table-walk reference model.
module tb_sccb_init_seq;

    localparam int          ADDR_W = 4;
    localparam int          NENT   = 16;
    localparam logic [15:0] GAP    = 16'd200;
    localparam logic [23:0] TMO    = 24'd1000;
    localparam logic [23:0] END_E  = 24'hC0_0000;

    logic              clk  = 1'b0;
    logic              rstn = 1'b1;
    logic              go   = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic              sccb_start;
    logic [25:0]       sccb_data;
    logic              sccb_busy;
    logic [7:0]        sccb_rdata;
    logic              running, done, err_verify, err_timeout;
    logic [ADDR_W-1:0] err_index;

    int errors = 0;
    int checks = 0;

    sccb_init_seq #(
        .DEV_ID       (8'h42),
        .ADDR_W       (ADDR_W),
        .GAP_CYC      (GAP),
        .XFER_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .go          (go),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sccb_start  (sccb_start),
        .sccb_data   (sccb_data),
        .sccb_busy   (sccb_busy),
        .sccb_rdata  (sccb_rdata),
        .running     (running),
        .done        (done),
        .err_verify  (err_verify),
        .err_timeout (err_timeout),
        .err_index   (err_index)
    );

    always #5 clk = ~clk;

    // Synchronous table ROM: data follows the address by one cycle
    logic [23:0] rom_mem [NENT];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // SCCB master model
    int         busy_len = 10;
    bit         stuck    = 1'b0;
    bit         no_ack   = 1'b0;
    logic [7:0] rd_q [$];
    int         bcnt;
    logic [1:0] cur_op;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sccb_busy  <= 1'b0;
            sccb_rdata <= 8'h00;
            bcnt       <= 0;
            cur_op     <= 2'b00;
        end else if (sccb_start) begin
            cur_op <= sccb_data[25:24];
            if (!no_ack) begin
                sccb_busy <= 1'b1;
                bcnt      <= busy_len;
            end
        end else if (sccb_busy && !stuck) begin
            if (bcnt <= 1) begin
                sccb_busy <= 1'b0;
                if (cur_op == 2'b10 && rd_q.size() > 0) sccb_rdata <= rd_q.pop_front();
            end else begin
                bcnt <= bcnt - 1;
            end
        end
    end

    // Cycle counter and output monitor, sampled on the falling edge
    int          cyc = 0;
    logic [25:0] obs_word [$];
    int          obs_cyc [$];
    int          done_cnt = 0, done_cyc = 0, fall_cyc = 0, tmo_cyc = 0;
    logic        busy_prev = 1'b0, tmo_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sccb_start) begin
            obs_word.push_back(sccb_data);
            obs_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (busy_prev && !sccb_busy) fall_cyc = cyc;
        if (!tmo_prev && err_timeout) tmo_cyc = cyc;
        busy_prev = sccb_busy;
        tmo_prev  = err_timeout;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int val, input int lo, input int hi);
        checks++;
        assert (val >= lo && val <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d required=%0d..%0d", tag, val, lo, hi);
        end
    endtask

    function automatic logic [23:0] ent(input logic [1:0] op, input logic [7:0] sub, input logic [7:0] dat);
        return {op, 6'b0, sub, dat};
    endfunction

    task automatic set_table(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
        for (int i = 0; i < NENT; i++) rom_mem[i] = END_E;
        rom_mem[0] = e0;
        rom_mem[1] = e1;
        rom_mem[2] = e2;
    endtask

    task automatic clear_obs();
        obs_word.delete();
        obs_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_go(output int gcyc);
        @(negedge clk);
        go   = 1'b1;
        gcyc = cyc;
        @(negedge clk);
        go   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_range(tag, done_cnt, 1, 1000);
    endtask

    task automatic wait_starts(input string tag, input int num, input int budget);
        int n = 0;
        while (obs_word.size() < num && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_range(tag, obs_word.size(), num, 1000);
    endtask

    // Random table run checked against a direct walk of the table rules
    task automatic run_random(input int r);
        logic [23:0] tbl [NENT];
        logic [7:0]  rb [$];
        logic [25:0] exp_w [$];
        bit          exp_rd [$];
        logic [25:0] mask;
        logic [7:0]  sub, dat, rd;
        bit          ev;
        int          ei, k, n, kind, g;

        for (int i = 0; i < NENT; i++) tbl[i] = END_E;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 4);
            sub  = 8'($urandom);
            dat  = 8'($urandom);
            if (kind <= 1) begin
                tbl[i] = ent(2'b00, sub, dat);
            end else if (kind <= 3) begin
                tbl[i] = ent(2'b01, sub, dat);
                if ($urandom_range(0, 2) == 0) rb.push_back(dat ^ 8'($urandom_range(1, 255)));
                else rb.push_back(dat);
            end else begin
                tbl[i] = ent(2'b10, 8'h00, 8'($urandom_range(0, 1)));
            end
        end

        ev = 1'b0;
        ei = 0;
        k  = 0;
        for (int i = 0; i < NENT; i++) begin
            if (tbl[i][23:22] == 2'b11) break;
            if (tbl[i][23:22] == 2'b00) begin
                exp_w.push_back({2'b00, 8'h42, tbl[i][15:0]});
                exp_rd.push_back(1'b0);
            end else if (tbl[i][23:22] == 2'b01) begin
                exp_w.push_back({2'b01, 8'h42, tbl[i][15:8], 8'h00});
                exp_rd.push_back(1'b1);
                exp_w.push_back({2'b10, 8'h42, tbl[i][15:8], 8'h00});
                exp_rd.push_back(1'b1);
                rd = rb[k];
                k++;
                if (rd != tbl[i][7:0]) begin
                    if (!ev) ei = i;
                    ev = 1'b1;
                end
            end
        end

        for (int i = 0; i < NENT; i++) rom_mem[i] = tbl[i];
        rd_q     = rb;
        busy_len = $urandom_range(1, 20);
        clear_obs();
        pulse_go(g);
        wait_done($sformatf("r%0d_done_seen", r), 30000);
        repeat (2) @(negedge clk);
        check($sformatf("r%0d_starts", r), obs_word.size(), exp_w.size());
        for (int j = 0; j < exp_w.size(); j++) begin
            if (j < obs_word.size()) begin
                mask = exp_rd[j] ? 26'h3FF_FF00 : 26'h3FF_FFFF;
                check($sformatf("r%0d_word%0d", r, j), obs_word[j] & mask, exp_w[j] & mask);
            end
        end
        check($sformatf("r%0d_err_verify", r), err_verify, ev);
        if (ev) check($sformatf("r%0d_err_index", r), err_index, ei);
        check($sformatf("r%0d_err_timeout", r), err_timeout, 0);
        check($sformatf("r%0d_done_pulses", r), done_cnt, 1);
    endtask

    initial begin
        int g;

        // Reset state
        set_table(END_E, END_E, END_E);
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_sccb_start", sccb_start, 0);
        check("rst_sccb_data", sccb_data, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_errs", {err_verify, err_timeout}, 0);
        check("rst_err_index", err_index, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single WRITE with a long busy phase
        set_table(ent(2'b00, 8'h12, 8'h80), END_E, END_E);
        busy_len = 300;
        clear_obs();
        pulse_go(g);
        check("w_running", running, 1);
        wait_done("w_done_seen", 3000);
        repeat (2) @(negedge clk);
        check("w_starts", obs_word.size(), 1);
        check("w_word", obs_word[0], 26'h042_1280);
        check_range("w_gap_to_done", done_cyc - fall_cyc, int'(GAP), int'(GAP) + 8);
        check("w_done_pulses", done_cnt, 1);
        check("w_running_end", running, 0);
        check("w_data_idle", sccb_data, 0);
        check("w_errs", {err_verify, err_timeout}, 0);

        // VERIFY with matching read-back
        set_table(ent(2'b01, 8'h0A, 8'h76), END_E, END_E);
        busy_len = 20;
        rd_q = {8'h76};
        clear_obs();
        pulse_go(g);
        wait_done("vok_done_seen", 3000);
        repeat (2) @(negedge clk);
        check("vok_starts", obs_word.size(), 2);
        check("vok_ph1", obs_word[0][25:8], 18'h1_420A);
        check("vok_ph2", obs_word[1][25:8], 18'h2_420A);
        check("vok_err_verify", err_verify, 0);

        // VERIFY with mismatching read-back
        rd_q = {8'h73};
        clear_obs();
        pulse_go(g);
        wait_done("vbad_done_seen", 3000);
        repeat (2) @(negedge clk);
        check("vbad_err_verify", err_verify, 1);
        check("vbad_err_index", err_index, 0);
        check("vbad_done_pulses", done_cnt, 1);

        // DELAY 3 then WRITE: the write waits at least 3072 cycles
        set_table(ent(2'b10, 8'h00, 8'h03), ent(2'b00, 8'h11, 8'h01), END_E);
        busy_len = 5;
        clear_obs();
        pulse_go(g);
        wait_done("dly_done_seen", 6000);
        repeat (2) @(negedge clk);
        check("dly_starts", obs_word.size(), 1);
        check_range("dly_wait", obs_cyc[0] - g, 3072, 3100);
        check("dly_word", obs_word[0], 26'h042_1101);

        // Index wrap: 15 zero-length DELAYs, WRITE in the last slot, no END
        for (int i = 0; i < NENT - 1; i++) rom_mem[i] = ent(2'b10, 8'h00, 8'h00);
        rom_mem[NENT-1] = ent(2'b00, 8'h55, 8'hAA);
        clear_obs();
        pulse_go(g);
        wait_done("wrap_done_seen", 3000);
        repeat (2) @(negedge clk);
        check("wrap_starts", obs_word.size(), 1);
        check("wrap_word", obs_word[0], 26'h042_55AA);
        check("wrap_done_pulses", done_cnt, 1);

        // No busy acknowledge: short ACK timeout
        set_table(ent(2'b00, 8'h12, 8'h34), END_E, END_E);
        no_ack = 1'b1;
        clear_obs();
        pulse_go(g);
        wait_done("noack_done_seen", 200);
        repeat (2) @(negedge clk);
        check("noack_err_timeout", err_timeout, 1);
        check_range("noack_window", tmo_cyc - obs_cyc[0], 4, 8);
        check("noack_err_index", err_index, 0);
        no_ack = 1'b0;

        // Busy stuck high on entry 1: transaction timeout
        set_table(ent(2'b10, 8'h00, 8'h00), ent(2'b00, 8'h12, 8'h34), END_E);
        stuck = 1'b1;
        clear_obs();
        pulse_go(g);
        wait_done("tmo_done_seen", 3000);
        repeat (2) @(negedge clk);
        check("tmo_err_timeout", err_timeout, 1);
        check_range("tmo_cycles", tmo_cyc - obs_cyc[0], int'(TMO), int'(TMO) + 4);
        check("tmo_err_index", err_index, 1);
        check("tmo_starts", obs_word.size(), 1);
        check("tmo_done_pulses", done_cnt, 1);

        // Reset clears sticky flags
        rstn  = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check("rst2_err_timeout", err_timeout, 0);
        check("rst2_err_index", err_index, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-XFER after a verify error, then restart from entry 0
        set_table(ent(2'b01, 8'h33, 8'h01), ent(2'b00, 8'h22, 8'h44), END_E);
        busy_len = 300;
        rd_q = {8'h02};
        clear_obs();
        pulse_go(g);
        wait_starts("mid_third_start", 3, 3000);
        repeat (100) @(negedge clk);
        check("mid_err_before", err_verify, 1);
        check("mid_running_before", running, 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_data", sccb_data, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_err_verify", err_verify, 0);
        check("mid_rst_rom_addr", rom_addr, 0);
        check("mid_rst_start", sccb_start, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rd_q = {8'h02};
        clear_obs();
        pulse_go(g);
        wait_starts("restart_first_start", 1, 50);
        check("restart_entry0", obs_word[0][25:8], 18'h1_4233);
        wait_done("restart_done_seen", 3000);
        repeat (2) @(negedge clk);
        check("restart_starts", obs_word.size(), 3);
        check("restart_err_verify", err_verify, 1);
        check("restart_err_index", err_index, 0);

        // Random tables against the reference model
        for (int r = 0; r < 8; r++) run_random(r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
